see_cone_checker: RTL and testbench

SEE_CONE_CHECKER -- requirements
Module: see_cone_checker

---
 rtl/see_chk_pkg.sv | 27 ++
 rtl/see_rec_fifo.sv | 46 ++++
 rtl/see_cone_checker.sv | 126 ++++++++++++
 tb/tb_see_cone_checker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/see_chk_pkg.sv
// Shared types and field widths for the SEE cone checker.
// SEE_CHK_TIMESTAMP_EN widens records with a 32-bit timestamp field.
package see_chk_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMonitor,
        StMismatch,
        StReport
    } state_e;

    localparam logic CLASS_TRANS = 1'b0;
    localparam logic CLASS_PERS  = 1'b1;

    localparam int unsigned CLASS_W = 1;
    localparam int unsigned RUN_W   = 4;
    localparam int unsigned TS_W    = 32;

    localparam logic [RUN_W-1:0] RUN_MAX = 4'd15;

`ifdef SEE_CHK_TIMESTAMP_EN
    localparam int unsigned TS_FIELD_W = TS_W;
`else
    localparam int unsigned TS_FIELD_W = 0;
`endif

endpackage

// File: rtl/see_rec_fifo.sv
// Synchronous error-record FIFO; a pop in the same cycle frees room for a push.
// DEPTH must be a power of two, at least 2.
module see_rec_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/see_cone_checker.sv
// Compares golden and faulty cone outputs during injection campaigns and logs mismatch runs.
// Optional macro SEE_CHK_TIMESTAMP_EN appends a 32-bit mismatch-entry timestamp to records.
module see_cone_checker
    import see_chk_pkg::*;
#(
    parameter int unsigned VEC_W      = 16,
    parameter int unsigned GLITCH_MAX = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          inject_active,
    input  logic                                          sample_valid,
    input  logic                                          golden_o,
    input  logic                                          faulty_o,
    input  logic [VEC_W-1:0]                              vector_id,
    output logic                                          rec_valid,
    input  logic                                          rec_ready,
    output logic [VEC_W+CLASS_W+RUN_W+TS_FIELD_W-1:0]     rec_data,
    output logic [CNT_W-1:0]                              trans_cnt,
    output logic [CNT_W-1:0]                              pers_cnt,
    output logic                                          overflow
);

    localparam int unsigned REC_W = VEC_W + CLASS_W + RUN_W + TS_FIELD_W;

    state_e           state_q;
    logic [RUN_W-1:0] run_q;
    logic [VEC_W-1:0] vid_q;
    logic             mismatch;
    logic             is_pers;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] rec_in;

    assign mismatch  = sample_valid && (golden_o != faulty_o);
    assign is_pers   = (run_q >= RUN_W'(GLITCH_MAX));
    assign push      = (state_q == StReport);
    assign rec_valid = !fifo_empty;
    assign pop       = rec_valid && rec_ready;

`ifdef SEE_CHK_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q;
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + TS_W'(1);
            if (state_q == StMonitor && inject_active && mismatch) ts_q <= ts_cnt_q;
        end
    end

    assign rec_in = {(is_pers ? CLASS_PERS : CLASS_TRANS), run_q, vid_q, ts_q};
`else
    assign rec_in = {(is_pers ? CLASS_PERS : CLASS_TRANS), run_q, vid_q};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            run_q     <= '0;
            vid_q     <= '0;
            trans_cnt <= '0;
            pers_cnt  <= '0;
            overflow  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (inject_active) state_q <= StMonitor;
                end
                StMonitor: begin
                    // Falling inject_active wins over a simultaneous mismatch.
                    if (!inject_active) begin
                        state_q <= StIdle;
                    end else if (mismatch) begin
                        state_q <= StMismatch;
                        run_q   <= RUN_W'(1);
                        vid_q   <= vector_id;
                    end
                end
                StMismatch: begin
                    if (!inject_active) begin
                        state_q <= StReport;
                    end else if (sample_valid) begin
                        if (golden_o != faulty_o) begin
                            if (run_q != RUN_MAX) run_q <= run_q + RUN_W'(1);
                        end else begin
                            state_q <= StReport;
                        end
                    end
                end
                StReport: begin
                    state_q <= inject_active ? StMonitor : StIdle;
                    if (is_pers) begin
                        if (pers_cnt != '1) pers_cnt <= pers_cnt + CNT_W'(1);
                    end else begin
                        if (trans_cnt != '1) trans_cnt <= trans_cnt + CNT_W'(1);
                    end
                    if (fifo_full && !pop) overflow <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    see_rec_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (rec_in),
        .pop       (pop),
        .pop_data  (rec_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_see_cone_checker.sv
// Directed, table-driven bench for see_cone_checker with hand-computed expectations.
module tb_see_cone_checker;
    import see_chk_pkg::*;

    localparam int unsigned VEC_W = 16;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned REC_W = VEC_W + CLASS_W + RUN_W + TS_FIELD_W;

    logic              clk;
    logic              rst_n;
    logic              inject_active;
    logic              sample_valid;
    logic              golden_o;
    logic              faulty_o;
    logic [VEC_W-1:0]  vector_id;
    logic              rec_valid;
    logic              rec_ready;
    logic [REC_W-1:0]  rec_data;
    logic [CNT_W-1:0]  trans_cnt;
    logic [CNT_W-1:0]  pers_cnt;
    logic              overflow;

    int errors = 0;
    int checks = 0;

    see_cone_checker #(
        .VEC_W      (VEC_W),
        .GLITCH_MAX (3),
        .FIFO_DEPTH (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inject_active (inject_active),
        .sample_valid  (sample_valid),
        .golden_o      (golden_o),
        .faulty_o      (faulty_o),
        .vector_id     (vector_id),
        .rec_valid     (rec_valid),
        .rec_ready     (rec_ready),
        .rec_data      (rec_data),
        .trans_cnt     (trans_cnt),
        .pers_cnt      (pers_cnt),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        inj;
        logic        vld;
        logic        gold;
        logic        fault;
        logic [15:0] vid;
        logic        exp_rv;
        logic [20:0] exp_data;
        logic [3:0]  exp_tc;
        logic [3:0]  exp_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic inj, logic vld, logic gold, logic fault, logic [15:0] vid,
                                logic rv, logic [20:0] data, logic [3:0] tc, logic [3:0] pc);
        vec_t v;
        v.inj = inj; v.vld = vld; v.gold = gold; v.fault = fault; v.vid = vid;
        v.exp_rv = rv; v.exp_data = data; v.exp_tc = tc; v.exp_pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] rec_fields();
        return 21'(rec_data >> TS_FIELD_W);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; inject_active = 1'b0; sample_valid = 1'b0;
        golden_o = 1'b0; faulty_o = 1'b0; vector_id = '0; rec_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // One-sample transient: mismatch, match, then the REPORT cycle.
    task automatic transient(input logic [15:0] id, input logic ready_at_report);
        inject_active = 1'b1; sample_valid = 1'b1; golden_o = 1'b1; faulty_o = 1'b0;
        vector_id = id;
        step();
        golden_o = 1'b0;
        step();
        sample_valid = 1'b0;
        if (ready_at_report) rec_ready = 1'b1;
        step();
        if (ready_at_report) rec_ready = 1'b0;
    endtask

    task automatic drain(input string name, input logic [15:0] first_id, input int n);
        rec_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({name, " valid"}, 32'(rec_valid), 32'd1);
            chk({name, " data"}, 32'(rec_fields()), 32'h10000 | 32'(first_id + 16'(i)));
            step();
        end
        chk({name, " empty"}, 32'(rec_valid), 32'd0);
        rec_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; inject_active = 1'b0; sample_valid = 1'b0;
        golden_o = 1'b0; faulty_o = 1'b0; vector_id = '0; rec_ready = 1'b0;
        #12;
        chk("reset rec_valid", 32'(rec_valid), 32'd0);
        chk("reset rec_data", 32'(rec_data), 32'd0);
        chk("reset trans_cnt", 32'(trans_cnt), 32'd0);
        chk("reset pers_cnt", 32'(pers_cnt), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        do_reset();

        // inj vld gold fault vid | rv data tc pc
        tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 21'h0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 16'h0012, 0, 21'h0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 16'h0013, 0, 21'h0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 21'h010012, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 21'h0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 16'h0040, 0, 21'h0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 16'h0041, 0, 21'h0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 16'h0042, 0, 21'h0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 16'h0043, 0, 21'h0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 16'h0044, 0, 21'h0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 16'h0045, 0, 21'h0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 16'h0046, 0, 21'h0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 21'h150040, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 21'h0, 1, 1));
        tbl.push_back(mk(1, 1, 1, 0, 16'h0021, 0, 21'h0, 1, 1));
        tbl.push_back(mk(1, 1, 1, 0, 16'h0022, 0, 21'h0, 1, 1));
        tbl.push_back(mk(1, 1, 1, 1, 16'h0023, 0, 21'h0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 21'h020021, 2, 1));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 21'h0, 2, 1));
        tbl.push_back(mk(1, 1, 1, 0, 16'h0033, 0, 21'h0, 2, 1));
        tbl.push_back(mk(1, 1, 1, 0, 16'h0034, 0, 21'h0, 2, 1));
        tbl.push_back(mk(1, 1, 1, 0, 16'h0035, 0, 21'h0, 2, 1));
        tbl.push_back(mk(0, 1, 1, 0, 16'h0036, 0, 21'h0, 2, 1));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 21'h130033, 2, 2));
        tbl.push_back(mk(0, 1, 1, 0, 16'h0050, 0, 21'h0, 2, 2));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 21'h0, 2, 2));
        tbl.push_back(mk(0, 1, 1, 0, 16'h0051, 0, 21'h0, 2, 2));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 21'h0, 2, 2));
        tbl.push_back(mk(1, 1, 1, 1, 16'h0052, 0, 21'h0, 2, 2));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 21'h0, 2, 2));

        rec_ready = 1'b1;
        foreach (tbl[i]) begin
            inject_active = tbl[i].inj;
            sample_valid  = tbl[i].vld;
            golden_o      = tbl[i].gold;
            faulty_o      = tbl[i].fault;
            vector_id     = tbl[i].vid;
            step();
            chk($sformatf("vec%0d rec_valid", i), 32'(rec_valid), 32'(tbl[i].exp_rv));
            if (tbl[i].exp_rv)
                chk($sformatf("vec%0d rec_data", i), 32'(rec_fields()), 32'(tbl[i].exp_data));
            chk($sformatf("vec%0d trans_cnt", i), 32'(trans_cnt), 32'(tbl[i].exp_tc));
            chk($sformatf("vec%0d pers_cnt", i), 32'(pers_cnt), 32'(tbl[i].exp_pc));
        end
        chk("table overflow", 32'(overflow), 32'd0);

        // Six transients against a stalled consumer: four held, two dropped.
        do_reset();
        inject_active = 1'b1;
        step();
        for (int i = 0; i < 6; i++) transient(16'h0100 + 16'(i), 1'b0);
        chk("ovf trans_cnt", 32'(trans_cnt), 32'd6);
        chk("ovf overflow", 32'(overflow), 32'd1);
        step();
        chk("ovf stable data", 32'(rec_fields()), 32'h10100);
        drain("ovf drain", 16'h0100, 4);
        chk("ovf sticky", 32'(overflow), 32'd1);

        // Full FIFO with pop and push on the same edge: no drop.
        do_reset();
        inject_active = 1'b1;
        step();
        for (int i = 0; i < 4; i++) transient(16'h0200 + 16'(i), 1'b0);
        chk("simul pre overflow", 32'(overflow), 32'd0);
        transient(16'h0204, 1'b1);
        chk("simul overflow", 32'(overflow), 32'd0);
        chk("simul trans_cnt", 32'(trans_cnt), 32'd5);
        drain("simul drain", 16'h0201, 4);

        // Counter saturation at 2^CNT_W-1.
        do_reset();
        inject_active = 1'b1;
        rec_ready = 1'b1;
        step();
        for (int i = 0; i < 15; i++) transient(16'h0300 + 16'(i), 1'b0);
        chk("sat trans_cnt 15", 32'(trans_cnt), 32'd15);
        for (int i = 0; i < 2; i++) transient(16'h0310 + 16'(i), 1'b0);
        chk("sat trans_cnt hold", 32'(trans_cnt), 32'd15);
        chk("sat pers_cnt", 32'(pers_cnt), 32'd0);
        chk("sat overflow", 32'(overflow), 32'd0);
        rec_ready = 1'b0;

        // Asynchronous reset during MISMATCH discards everything.
        do_reset();
        inject_active = 1'b1;
        step();
        transient(16'h0400, 1'b0);
        sample_valid = 1'b1; golden_o = 1'b1; faulty_o = 1'b0; vector_id = 16'h0401;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst rec_valid", 32'(rec_valid), 32'd0);
        chk("arst rec_data", 32'(rec_data), 32'd0);
        chk("arst trans_cnt", 32'(trans_cnt), 32'd0);
        chk("arst pers_cnt", 32'(pers_cnt), 32'd0);
        chk("arst overflow", 32'(overflow), 32'd0);
        step();
        rst_n = 1'b1;
        faulty_o = 1'b1;
        rec_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("arst no record", 32'(rec_valid), 32'd0);
        chk("arst no count", 32'(trans_cnt) + 32'(pers_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
